// File: rtl/seq_mult_unit.sv
// seq_mult_unit: iterative shift-add multiplier, signed (MULT) / unsigned (MULTU).
// One partial product per clock; result after WIDTH+1 cycles, held until the next completion.
module seq_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         Signal,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] dataOut
);

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam int         CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   dout_q, dout_d;

  // Operand decode: the mode only matters at capture time, where it folds into
  // the magnitudes and the result sign, so no separate mode register is kept.
  logic             legal, sgn;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign legal = (Signal == OP_MULT) || (Signal == OP_MULTU);
  assign sgn   = (Signal == OP_MULT);
  // Negating -2^(WIDTH-1) yields itself, which read unsigned is the correct magnitude.
  assign mag_a = (sgn && dataA[WIDTH-1]) ? -dataA : dataA;
  assign mag_b = (sgn && dataB[WIDTH-1]) ? -dataB : dataB;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
    end
  end

  // Next-state and datapath: capture in IDLE, shift-add in RUN, sign-fix in DONE.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dout_d   = dout_q;
    unique case (state_q)
      IDLE: begin
        if (start && legal) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = sgn & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        dout_d  = neg_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dataOut = dout_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Bench for seq_mult_unit: three instances (WIDTH 8/16/32) sharing clock and reset.
module tb_seq_mult_unit;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          cyc = 0;
  int          npass = 0;
  int          ntot = 0;
  int          wd[3] = '{8, 16, 32};

  logic        st[3];
  logic [5:0]  sg[3];
  logic [63:0] av[3], bv[3];
  logic        bz[3], dn[3];
  logic [127:0] dout[3];
  logic [15:0] do0;
  logic [31:0] do1;
  logic [63:0] do2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mult_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(st[0]), .Signal(sg[0]),
    .dataA(av[0][7:0]), .dataB(bv[0][7:0]), .busy(bz[0]), .done(dn[0]), .dataOut(do0));
  seq_mult_unit #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(st[1]), .Signal(sg[1]),
    .dataA(av[1][15:0]), .dataB(bv[1][15:0]), .busy(bz[1]), .done(dn[1]), .dataOut(do1));
  seq_mult_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(st[2]), .Signal(sg[2]),
    .dataA(av[2][31:0]), .dataB(bv[2][31:0]), .busy(bz[2]), .done(dn[2]), .dataOut(do2));

  assign dout[0] = 128'(do0);
  assign dout[1] = 128'(do1);
  assign dout[2] = 128'(do2);

  typedef struct {
    logic [5:0]   sig;
    logic [63:0]  a, b;
    logic [127:0] exp;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference product: sign-extend to 128 bits as the mode dictates, multiply, keep 2*w bits.
  function automatic logic [127:0] ref_prod(input int w, input logic [5:0] sig,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0] m, ea, eb, p;
    m  = (128'd1 << w) - 128'd1;
    ea = {64'b0, a} & m;
    eb = {64'b0, b} & m;
    if (sig == MULT) begin
      if (a[w-1]) ea = ea | ~m;
      if (b[w-1]) eb = eb | ~m;
    end
    p = ea * eb;
    return p & ((128'd1 << (2*w)) - 128'd1);
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (w-1);
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  // Drive a start strobe (caller sits just after an edge); scramble operands once sampled.
  task automatic start_op(input int k, input logic [5:0] sig, input logic [63:0] a, input logic [63:0] b);
    st[k] = 1'b1; sg[k] = sig; av[k] = a; bv[k] = b;
    @(posedge clk); #1;
    st[k] = 1'b0; sg[k] = 6'($urandom); av[k] = {$urandom, $urandom}; bv[k] = {$urandom, $urandom};
  endtask

  // Wait for done (bounded); lat counts cycles after the start edge, bcnt counts busy samples.
  task automatic wait_done(input int k, output logic [127:0] p, output int lat,
                           output int bcnt, output int tdone);
    lat = 0;
    bcnt = bz[k] ? 1 : 0;
    while (!dn[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (bz[k] && !dn[k]) bcnt++;
    end
    if (!dn[k]) chk("done_timeout", 128'(lat), 128'(wd[k] + 1));
    p = dout[k];
    tdone = cyc;
  endtask

  task automatic rand_run(input int k, input int n);
    logic [127:0] p;
    logic [63:0]  a, b;
    logic [5:0]   sig;
    int lat, bc, td;
    for (int i = 0; i < n; i++) begin
      sig = $urandom_range(0, 1) ? MULT : MULTU;
      a = pick(wd[k]);
      b = pick(wd[k]);
      start_op(k, sig, a, b);
      wait_done(k, p, lat, bc, td);
      chk($sformatf("rand_w%0d %0h*%0h", wd[k], a, b), p, ref_prod(wd[k], sig, a, b));
    end
  endtask

  initial begin
    logic [127:0] p;
    int lat, bc, t1, t2;
    for (int k = 0; k < 3; k++) begin st[k] = 0; sg[k] = 0; av[k] = 0; bv[k] = 0; end

    vt[0] = '{MULTU, 64'hFFFFFFFF, 64'hFFFFFFFF, 128'hFFFFFFFE00000001};
    vt[1] = '{MULT,  64'h80000000, 64'h80000000, 128'h4000000000000000};
    vt[2] = '{MULT,  64'hFFFFFFFF, 64'd5,        128'hFFFFFFFFFFFFFFFB};
    vt[3] = '{MULT,  64'h80000000, 64'd1,        128'hFFFFFFFF80000000};
    vt[4] = '{MULTU, 64'd0,        64'hFFFFFFFF, 128'd0};
    vt[5] = '{MULT,  64'h7FFFFFFF, 64'h7FFFFFFF, 128'h3FFFFFFF00000001};
    vt[6] = '{MULT,  64'hFFFFFFFF, 64'hFFFFFFFF, 128'd1};
    vt[7] = '{MULTU, 64'd6,        64'd7,        128'd42};

    // Reset state
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", 128'(bz[k]), 128'd0);
      chk("rst_done", 128'(dn[k]), 128'd0);
      chk("rst_dout", dout[k], 128'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed table on WIDTH=32
    for (int i = 0; i < 8; i++) begin
      start_op(2, vt[i].sig, vt[i].a, vt[i].b);
      wait_done(2, p, lat, bc, t1);
      chk($sformatf("vec%0d", i), p, vt[i].exp);
      chk($sformatf("vec%0d_lat", i), 128'(lat), 128'd33);
      if (i == 0) chk("busy_cycles", 128'(bc), 128'd33);
    end
    @(posedge clk); #1;
    chk("done_drop", 128'(dn[2]), 128'd0);

    // Second start mid-RUN is ignored
    start_op(2, MULTU, 64'd6, 64'd7);
    repeat (4) @(posedge clk); #1;
    start_op(2, MULT, 64'd100, 64'hFFFFFFFD);
    wait_done(2, p, lat, bc, t1);
    chk("midrun_start", p, 128'd42);
    repeat (3) @(posedge clk); #1;
    chk("midrun_no_requeue", 128'(bz[2]), 128'd0);

    // Illegal opcode: no busy, result held
    start_op(2, 6'b111111, 64'd9, 64'd9);
    chk("illegal_busy", 128'(bz[2]), 128'd0);
    repeat (40) @(posedge clk); #1;
    chk("illegal_dout", dout[2], 128'd42);
    chk("illegal_done", 128'(dn[2]), 128'd0);

    // Reset mid-operation
    start_op(2, MULTU, 64'd7, 64'd9);
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 128'(bz[2]), 128'd0);
    chk("midrst_done", 128'(dn[2]), 128'd0);
    chk("midrst_dout", dout[2], 128'd0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    start_op(2, MULTU, 64'd3, 64'd5);
    wait_done(2, p, lat, bc, t1);
    chk("postrst_prod", p, 128'd15);
    chk("postrst_lat", 128'(lat), 128'd33);

    // Back-to-back on WIDTH=8: second start lands in the done cycle
    start_op(0, MULTU, 64'd200, 64'd200);
    wait_done(0, p, lat, bc, t1);
    chk("b2b_first", p, 128'h9C40);
    start_op(0, MULT, 64'h9C, 64'h03);
    wait_done(0, p, lat, bc, t2);
    chk("b2b_second", p, 128'hFED4);
    chk("b2b_spacing", 128'(t2 - t1), 128'd10);

    // Random regression on all three widths concurrently
    fork
      rand_run(0, 3000);
      rand_run(1, 1700);
      rand_run(2, 900);
    join

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
